// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Result flags packed as {gt, lt, eq}.
    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_LT   = 3'b010;
    localparam logic [2:0] RES_EQ   = 3'b001;
    localparam logic [2:0] RES_NONE = 3'b000;

    function automatic int ndig(input int width, input int digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/seq_magnitude_comparator_if.sv
// Operand/result handshake bundle for seq_magnitude_comparator.
interface seq_magnitude_comparator_if #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 2
);
    localparam int NDIG = cmp_pkg::ndig(WIDTH, DIGIT);
    localparam int CW   = $clog2(NDIG + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             signed_mode;
    logic             gt_in;
    logic             lt_in;
    logic             out_valid;
    logic             out_ready;
    logic             xgty;
    logic             xlty;
    logic             xety;
    logic [CW-1:0]    digits_used;

    modport master (
        output in_valid, x, y, signed_mode, gt_in, lt_in, out_ready,
        input  in_ready, out_valid, xgty, xlty, xety, digits_used
    );

    modport slave (
        input  in_valid, x, y, signed_mode, gt_in, lt_in, out_ready,
        output in_ready, out_valid, xgty, xlty, xety, digits_used
    );
endinterface

// File: rtl/seq_magnitude_comparator_digit_compare.sv
// Combinational compare of one DIGIT-bit slice of each operand.
module digit_compare #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    output logic             gt,
    output logic             lt,
    output logic             eq
);
    assign gt = (a_i > b_i);
    assign lt = (a_i < b_i);
    assign eq = (a_i == b_i);
endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator with higher-word cascade.
// Optional build macro CMP_EARLY_EXIT_EN: finish on the first unequal digit.
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    seq_magnitude_comparator_if.slave bus
);
    localparam int NDIG = ndig(WIDTH, DIGIT);
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CW   = $clog2(NDIG + 1);
    localparam logic [IDXW-1:0]  LAST_IDX  = IDXW'(NDIG - 1);
    localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);

`ifdef CMP_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    state_t           state_q;
    logic [WIDTH-1:0] xa_q;
    logic [WIDTH-1:0] ya_q;
    logic [IDXW-1:0]  idx_q;
    logic [CW-1:0]    cnt_q;
    logic             found_q;
    logic [2:0]       res_q;
    logic [2:0]       flags_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [IDXW-1:0]  ridx;
    logic [DIGIT-1:0] xd;
    logic [DIGIT-1:0] yd;
    logic             dgt;
    logic             dlt;
    logic             deq;
    logic [2:0]       res_d;
    logic             last_d;
    logic             exit_d;

    // Digit idx counts from the MSB end; ridx is its position from the LSB end.
    assign ridx = LAST_IDX - idx_q;
    assign xd   = xa_q[int'(ridx) * DIGIT +: DIGIT];
    assign yd   = ya_q[int'(ridx) * DIGIT +: DIGIT];

    digit_compare #(.DIGIT(DIGIT)) u_digit (
        .a_i (xd),
        .b_i (yd),
        .gt  (dgt),
        .lt  (dlt),
        .eq  (deq)
    );

    // Once a digit has differed, later digits cannot change the verdict.
    assign res_d  = found_q ? res_q : (dgt ? RES_GT : (dlt ? RES_LT : RES_EQ));
    assign last_d = (idx_q == LAST_IDX);
    assign exit_d = last_d || (EARLY_EXIT && !deq);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            xa_q        <= '0;
            ya_q        <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            found_q     <= 1'b0;
            res_q       <= RES_NONE;
            flags_q     <= RES_NONE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        // Flipping the sign bits maps two's-complement order onto unsigned order.
                        xa_q       <= bus.x ^ (bus.signed_mode ? SIGN_MASK : '0);
                        ya_q       <= bus.y ^ (bus.signed_mode ? SIGN_MASK : '0);
                        idx_q      <= '0;
                        cnt_q      <= '0;
                        found_q    <= 1'b0;
                        res_q      <= RES_NONE;
                        in_ready_q <= 1'b0;
                        if (bus.gt_in || bus.lt_in) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            flags_q     <= bus.gt_in ? RES_GT : RES_LT;
                        end else begin
                            state_q <= RUN;
                            flags_q <= RES_NONE;
                        end
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    idx_q <= idx_q + 1'b1;
                    if (!found_q && !deq) begin
                        found_q <= 1'b1;
                        res_q   <= res_d;
                    end
                    if (exit_d) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        flags_q     <= res_d;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q && !rst;
    assign bus.out_valid   = out_valid_q;
    assign bus.xgty        = flags_q[2];
    assign bus.xlty        = flags_q[1];
    assign bus.xety        = flags_q[0];
    assign bus.digits_used = cnt_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed self-checking bench for seq_magnitude_comparator (WIDTH=16, DIGIT=2).
module tb_seq_magnitude_comparator;

`ifdef CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_magnitude_comparator_if #(.WIDTH(16), .DIGIT(2)) bus ();

    seq_magnitude_comparator #(.WIDTH(16), .DIGIT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Accepts one transaction and returns the edge count from accept to out_valid.
    task automatic run_txn(input logic [15:0] xv, input logic [15:0] yv,
                           input logic sm, input logic g, input logic l,
                           output int lat);
        int waitc;
        waitc = 0;
        @(negedge clk);
        while (!bus.in_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_wait in_ready=%b required 1", bus.in_ready);
        end
        bus.x = xv;
        bus.y = yv;
        bus.signed_mode = sm;
        bus.gt_in = g;
        bus.lt_in = l;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.gt_in = 1'b0;
        bus.lt_in = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic pop();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready got=%b want=0", bus.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.xgty, bus.xlty, bus.xety} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=0000",
                     {bus.out_valid, bus.xgty, bus.xlty, bus.xety});
        end
        checks++;
        if (bus.digits_used !== 4'd0) begin
            errors++;
            $display("FAIL reset_digits got=%0d want=0", bus.digits_used);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_in_ready got=%b want=1", bus.in_ready);
        end
    endtask

    task automatic test_equal();
        int lat;
        run_txn(16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, lat);
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL eq_latency got=%0d want=9", lat);
        end
        checks++;
        if ({bus.xgty, bus.xlty, bus.xety} !== 3'b001) begin
            errors++;
            $display("FAIL eq_flags got=%b want=001", {bus.xgty, bus.xlty, bus.xety});
        end
        checks++;
        if (bus.digits_used !== 4'd8) begin
            errors++;
            $display("FAIL eq_digits got=%0d want=8", bus.digits_used);
        end
        pop();
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL eq_release got=%b want=01", {bus.out_valid, bus.in_ready});
        end
    endtask

    // Table rows: x, y, signed_mode, expected {gt,lt,eq}, 1-based first unequal digit.
    task automatic test_order(input string name, input logic sm,
                              input logic [15:0] xs [4], input logic [15:0] ys [4],
                              input logic [2:0] fl [4], input int ks [4]);
        int lat;
        int exp_lat;
        int exp_du;
        for (int i = 0; i < 4; i++) begin
            exp_lat = EARLY ? 1 + ks[i] : 9;
            exp_du  = EARLY ? ks[i] : 8;
            run_txn(xs[i], ys[i], sm, 1'b0, 1'b0, lat);
            checks++;
            if ({bus.xgty, bus.xlty, bus.xety} !== fl[i]) begin
                errors++;
                $display("FAIL %s_flags[%0d] got=%b want=%b", name, i,
                         {bus.xgty, bus.xlty, bus.xety}, fl[i]);
            end
            checks++;
            if (lat !== exp_lat) begin
                errors++;
                $display("FAIL %s_latency[%0d] got=%0d want=%0d", name, i, lat, exp_lat);
            end
            checks++;
            if (int'(bus.digits_used) !== exp_du) begin
                errors++;
                $display("FAIL %s_digits[%0d] got=%0d want=%0d", name, i, bus.digits_used, exp_du);
            end
            pop();
        end
    endtask

    task automatic test_unsigned();
        logic [15:0] xs [4] = '{16'h8000, 16'h0005, 16'h0001, 16'hFFFF};
        logic [15:0] ys [4] = '{16'h7FFF, 16'h0003, 16'h0002, 16'hFFFF};
        logic [2:0]  fl [4] = '{3'b100, 3'b100, 3'b010, 3'b001};
        int          ks [4] = '{1, 7, 8, 8};
        test_order("unsigned", 1'b0, xs, ys, fl, ks);
    endtask

    task automatic test_signed();
        logic [15:0] xs [4] = '{16'h8000, 16'hFFFF, 16'h0003, 16'hFFFE};
        logic [15:0] ys [4] = '{16'h7FFF, 16'h0001, 16'hFFFE, 16'hFFFF};
        logic [2:0]  fl [4] = '{3'b010, 3'b010, 3'b100, 3'b010};
        int          ks [4] = '{1, 1, 1, 8};
        test_order("signed", 1'b1, xs, ys, fl, ks);
    endtask

    task automatic test_cascade();
        int lat;
        logic [1:0] casc [3] = '{2'b11, 2'b01, 2'b10};
        logic [2:0] fl   [3] = '{3'b100, 3'b010, 3'b100};
        for (int i = 0; i < 3; i++) begin
            run_txn(casc[i] == 2'b01 ? 16'hFFFF : 16'h0000,
                    casc[i] == 2'b01 ? 16'h0000 : 16'hFFFF,
                    1'b0, casc[i][1], casc[i][0], lat);
            checks++;
            if (lat !== 1) begin
                errors++;
                $display("FAIL cascade_latency[%0d] got=%0d want=1", i, lat);
            end
            checks++;
            if ({bus.xgty, bus.xlty, bus.xety} !== fl[i]) begin
                errors++;
                $display("FAIL cascade_flags[%0d] got=%b want=%b", i,
                         {bus.xgty, bus.xlty, bus.xety}, fl[i]);
            end
            checks++;
            if (bus.digits_used !== 4'd0) begin
                errors++;
                $display("FAIL cascade_digits[%0d] got=%0d want=0", i, bus.digits_used);
            end
            pop();
        end
    endtask

    task automatic test_hold();
        int lat;
        run_txn(16'h0005, 16'h0003, 1'b0, 1'b0, 1'b0, lat);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({bus.out_valid, bus.in_ready, bus.xgty, bus.xlty, bus.xety} !== 5'b10100) begin
                errors++;
                $display("FAIL hold[%0d] got=%b want=10100", c,
                         {bus.out_valid, bus.in_ready, bus.xgty, bus.xlty, bus.xety});
            end
            @(negedge clk);
        end
        pop();
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL hold_release got=%b want=01", {bus.out_valid, bus.in_ready});
        end
        run_txn(16'd3, 16'd3, 1'b0, 1'b0, 1'b0, lat);
        checks++;
        if ({bus.xgty, bus.xlty, bus.xety} !== 3'b001) begin
            errors++;
            $display("FAIL hold_next_flags got=%b want=001", {bus.xgty, bus.xlty, bus.xety});
        end
        pop();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        @(negedge clk);
        bus.x = 16'h0001;
        bus.y = 16'h0002;
        bus.signed_mode = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL midrun_reset got=%b want=01", {bus.out_valid, bus.in_ready});
        end
        run_txn(16'd3, 16'd3, 1'b0, 1'b0, 1'b0, lat);
        checks++;
        if ({bus.xgty, bus.xlty, bus.xety} !== 3'b001) begin
            errors++;
            $display("FAIL midrun_next_flags got=%b want=001", {bus.xgty, bus.xlty, bus.xety});
        end
        checks++;
        if (lat !== 9 || bus.digits_used !== 4'd8) begin
            errors++;
            $display("FAIL midrun_next_timing got=%0d/%0d want=9/8", lat, bus.digits_used);
        end
        pop();
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.x = '0;
        bus.y = '0;
        bus.signed_mode = 1'b0;
        bus.gt_in = 1'b0;
        bus.lt_in = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_equal();
        test_unsigned();
        test_signed();
        test_cascade();
        test_hold();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
- Parametrised, multi-cycle magnitude comparator for the GCD datapath.
- Scans operands MSB-first, DIGIT bits per cycle, with an external higher-word cascade.
- Supports signed or unsigned comparison per transaction.
- Valid/ready handshake on input and result; one transaction in flight.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of DIGIT and at least DIGIT.
- DIGIT, 2, bits compared per cycle; NDIG = WIDTH/DIGIT digits per operand.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and mode valid.
- in_ready  output  1  block can accept operands.
- x  input  WIDTH  operand X.
- y  input  WIDTH  operand Y.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned.
- gt_in  input  1  cascade: higher word already has X > Y.
- lt_in  input  1  cascade: higher word already has X < Y.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- xgty  output  1  X > Y.
- xlty  output  1  X < Y.
- xety  output  1  X == Y.
- digits_used  output  $clog2(NDIG+1)  number of digits examined for this result.

Behaviour:
- Reset: state IDLE. in_ready=0 during the reset cycle, 1 afterwards. out_valid, xgty, xlty, xety = 0. digits_used = 0. Internal registers cleared.
- Reset mid-RUN or in DONE: current result is dropped and the FSM returns to IDLE; nothing is emitted.
- IDLE:
  - in_ready=1. Accept on in_valid && in_ready.
  - On accept, latch x and y. When signed_mode=1, invert bit WIDTH-1 of both latched operands so an unsigned scan gives the signed order.
  - Clear the digit index and go to RUN.
  - If gt_in or lt_in is set at accept, go directly to DONE: xgty=gt_in, xlty=!gt_in && lt_in (gt_in wins when both are set), xety=0, digits_used=0.
- RUN:
  - in_ready=0.
  - Each cycle compares digit idx, MSB-first (bits WIDTH-1-idx*DIGIT down to WIDTH-DIGIT-idx*DIGIT), combinationally.
  - Each digit increments digits_used.
  - Any unequal digit sets the result flags (first unequal digit wins).
  - After the last digit (idx = NDIG-1), go to DONE; if no digit differed, xety=1.
- DONE:
  - out_valid=1; flags, digits_used and out_valid hold stable until out_ready.
  - On out_valid && out_ready, go to IDLE and clear out_valid. in_ready rises the cycle after.
  - No result/accept overlap in the same cycle.
- Flags are one-hot whenever out_valid=1.
- Latency, counted in edges from the accept edge to out_valid high:
  - cascade: 1
  - full scan: 1+NDIG

Optional Feature:
- Macro: CMP_EARLY_EXIT_EN.
- Defined: RUN leaves for DONE on the edge that evaluates the first unequal digit. Latency is 1+k, where k is the 1-based position of the first unequal digit; digits_used=k.
- Undefined: always scans all NDIG digits (constant latency 1+NDIG, digits_used=NDIG). Flags still reflect the first unequal digit.
- Cascade short-circuit is present in both builds.

Decomposition:
- Package cmp_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - result encoding constants RES_GT / RES_LT / RES_EQ
  - localparam helper for NDIG
- Sub-module digit_compare: purely combinational DIGIT-bit compare with outputs gt, lt, eq. Instantiated once and fed by the indexed slice.

Test Plan:
- WIDTH=16, DIGIT=2, unsigned, x=y=0x1234, cascade 0 -> xety=1, digits_used=8, out_valid 9 edges after accept (either build).
- Unsigned x=0x8000, y=0x7FFF -> xgty=1. Early-exit build: out_valid after 2 edges, digits_used=1. Without early exit: 9 edges, digits_used=8.
- Same operands with signed_mode=1 -> xlty=1 (-32768 < 32767). Check both builds.
- gt_in=1 and lt_in=1, x=0, y=0xFFFF -> xgty=1, digits_used=0, out_valid after 1 edge.
- Result with out_ready held low 5 cycles -> flags and out_valid stable, in_ready=0 throughout. Pulse out_ready -> in_ready=1 next cycle; a new accept works.
- rst asserted on RUN cycle 3 with x=0x0001, y=0x0002 -> next cycle out_valid=0, in_ready=1. A fresh x=3, y=3 then yields xety=1.
